// File: rtl/box_detect.sv
// box_detect: colour-window bounding-box detector on an HDMI-style pixel stream.
//
// i_pack layout, MSB first: {r[7:0], g[7:0], b[7:0], de, hsync, vsync, rsvd, x[XW-1:0], y[YW-1:0]}
//
// Ports:
//   clk, rstn            pixel clock, async active-low reset
//   en                   detection enable; low forces IDLE and clears the box
//   i_pack               packed pixel stream (layout above)
//   lo_color, hi_color   inclusive per-channel match window, {r,g,b}
//   start_x/y, end_x/y   committed bounding box (registered)
//   box_valid            committed box holds at least MIN_PIXELS matches
//   frame_done           one-cycle pulse on each commit

module hdmi_unpack #(
  parameter int XW = 11,
  parameter int YW = 10
) (
  input  logic [3*8+4+XW+YW-1:0] pack,
  output logic [7:0]             r,
  output logic [7:0]             g,
  output logic [7:0]             b,
  output logic                   de,
  output logic                   hsync,
  output logic                   vsync,
  output logic [XW-1:0]          x,
  output logic [YW-1:0]          y
);
  logic unused_rsvd;

  assign {r, g, b, de, hsync, vsync, unused_rsvd, x, y} = pack;
endmodule

// state  | meaning
// IDLE   | disabled or waiting for the first frame edge; accumulators held at init
// SCAN   | accumulating the bounding box of matched pixels
// COMMIT | one cycle after a frame edge; box just registered, accumulators at init
module box_detect #(
  parameter int unsigned H_ACT      = 12'd1280,
  parameter int unsigned V_ACT      = 12'd720,
  parameter int unsigned MIN_PIXELS = 16,
  localparam int XW = $clog2(H_ACT),
  localparam int YW = $clog2(V_ACT)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   en,
  input  logic [3*8+4+XW+YW-1:0] i_pack,
  input  logic [23:0]            lo_color,
  input  logic [23:0]            hi_color,
  output logic [XW-1:0]          start_x,
  output logic [XW-1:0]          end_x,
  output logic [YW-1:0]          start_y,
  output logic [YW-1:0]          end_y,
  output logic                   box_valid,
  output logic                   frame_done
);
  localparam int CW = $clog2(H_ACT * V_ACT + 1);
  localparam logic [XW-1:0] X_INIT  = XW'(H_ACT - 1);
  localparam logic [YW-1:0] Y_INIT  = YW'(V_ACT - 1);
  localparam logic [CW-1:0] CNT_MIN = CW'(MIN_PIXELS);
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  state_t state, state_nx;

  logic [7:0]    r, g, b;
  logic          de, vsync, unused_hsync;
  logic [XW-1:0] x;
  logic [YW-1:0] y;

  logic          vs_q, frame_edge, match;
  logic [XW-1:0] min_x, max_x;
  logic [YW-1:0] min_y, max_y;
  logic [CW-1:0] cnt;
  logic          acc_init, acc_upd, do_commit, do_clear;

  logic          box_ok;
  logic [XW-1:0] c_sx, c_ex;
  logic [YW-1:0] c_sy, c_ey;

  hdmi_unpack #(.XW(XW), .YW(YW)) u_unpack (
    .pack  (i_pack),
    .r     (r),
    .g     (g),
    .b     (b),
    .de    (de),
    .hsync (unused_hsync),
    .vsync (vsync),
    .x     (x),
    .y     (y)
  );

  assign frame_edge = vsync && !vs_q;
  assign match = de &&
                 (r >= lo_color[23:16]) && (r <= hi_color[23:16]) &&
                 (g >= lo_color[15:8])  && (g <= hi_color[15:8])  &&
                 (b >= lo_color[7:0])   && (b <= hi_color[7:0]);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      vs_q  <= 1'b0;
    end else begin
      state <= state_nx;
      vs_q  <= vsync;
    end
  end

  always_comb begin
    state_nx  = state;
    acc_init  = 1'b0;
    acc_upd   = 1'b0;
    do_commit = 1'b0;
    do_clear  = 1'b0;
    if (!en) begin
      state_nx = IDLE;
      acc_init = 1'b1;
      do_clear = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          acc_init = 1'b1;
          if (frame_edge) state_nx = SCAN;
        end
        SCAN: begin
          // The edge-cycle pixel belongs to neither frame and is dropped.
          if (frame_edge) begin
            state_nx  = COMMIT;
            do_commit = 1'b1;
            acc_init  = 1'b1;
          end else if (match) begin
            acc_upd = 1'b1;
          end
        end
        COMMIT: begin
          acc_init = 1'b1;
          state_nx = SCAN;
        end
        default: begin
          acc_init = 1'b1;
          state_nx = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      min_x <= X_INIT;
      max_x <= '0;
      min_y <= Y_INIT;
      max_y <= '0;
      cnt   <= '0;
    end else if (acc_init) begin
      min_x <= X_INIT;
      max_x <= '0;
      min_y <= Y_INIT;
      max_y <= '0;
      cnt   <= '0;
    end else if (acc_upd) begin
      if (x < min_x) min_x <= x;
      if (x > max_x) max_x <= x;
      if (y < min_y) min_y <= y;
      if (y > max_y) max_y <= y;
      if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
    end
  end

  // Zero means "no box" downstream, so a valid box never reports a 0 coordinate.
  assign box_ok = (cnt >= CNT_MIN);
  assign c_sx = !box_ok ? '0 : (min_x == '0) ? XW'(1) : min_x;
  assign c_ex = !box_ok ? '0 : (max_x == '0) ? XW'(1) : max_x;
  assign c_sy = !box_ok ? '0 : (min_y == '0) ? YW'(1) : min_y;
  assign c_ey = !box_ok ? '0 : (max_y == '0) ? YW'(1) : max_y;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      start_x    <= '0;
      end_x      <= '0;
      start_y    <= '0;
      end_y      <= '0;
      box_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else if (do_clear) begin
      start_x    <= '0;
      end_x      <= '0;
      start_y    <= '0;
      end_y      <= '0;
      box_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else if (do_commit) begin
      start_x    <= c_sx;
      end_x      <= c_ex;
      start_y    <= c_sy;
      end_y      <= c_ey;
      box_valid  <= box_ok;
      frame_done <= 1'b1;
    end else begin
      frame_done <= 1'b0;
    end
  end
endmodule

// File: doc/box_detect.md
BOX_DETECT -- requirements
Module: box_detect

Interface
REQ-001 SHALL have parameter H_ACT, default 12'd1280, meaning active pixels per line; XW = $clog2(H_ACT).
REQ-002 SHALL have parameter V_ACT, default 12'd720, meaning active lines per frame; YW = $clog2(V_ACT).
REQ-003 SHALL have parameter MIN_PIXELS, default 16, meaning the minimum matched-pixel count for a valid box.
REQ-004 SHALL have port clk, input, 1 bit: pixel clock, the same clock carried in i_pack; the block has one clock only.
REQ-005 SHALL have port rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port en, input, 1 bit: detection enable.
REQ-007 SHALL have port i_pack, input, 3*8+4+XW+YW bits: standard HDMI pack, unpacked internally with hdmi_unpack.
REQ-008 SHALL have ports lo_color and hi_color, input, 24 bits each ({r,g,b}): inclusive per-channel match window.
REQ-009 SHALL have ports start_x and end_x (output, XW bits) and start_y and end_y (output, YW bits): committed box, registered.
REQ-010 SHALL have port box_valid, output, 1 bit: the committed box is valid.
REQ-011 SHALL have port frame_done, output, 1 bit: one-cycle pulse on each commit.

Function
REQ-012 SHALL define match = de && (lo_r<=r<=hi_r) && (lo_g<=g<=hi_g) && (lo_b<=b<=hi_b); all comparisons unsigned.
REQ-013 SHALL define frame edge = vsync && !vs_q, where vs_q is vsync registered on clk.
REQ-014 SHALL implement an FSM with states IDLE, SCAN and COMMIT.
REQ-015 IDLE: accumulators are held at their init values; on a frame edge with en=1 the FSM goes to SCAN.
REQ-016 SCAN: on each cycle with match=1 and no frame edge, the accumulators update as follows.
- min_x = min(min_x, x); max_x = max(max_x, x).
- min_y = min(min_y, y); max_y = max(max_y, y).
- cnt = cnt + 1, saturating at all-ones.
REQ-017 SCAN: on a frame edge the FSM goes to COMMIT; the pixel in the edge cycle is ignored.
REQ-018 COMMIT (exactly one cycle), on the clock that enters it, the outputs SHALL register:
- start_x/start_y/end_x/end_y = min_x/min_y/max_x/max_y;
- box_valid = (cnt >= MIN_PIXELS);
- frame_done = 1.
REQ-019 COMMIT: the accumulators SHALL reinitialise in the same cycle, and the FSM SHALL return to SCAN unconditionally.
REQ-020 Latency SHALL be: committed outputs and frame_done visible 1 clk after the cycle the frame edge is sampled.
REQ-021 Init values SHALL be: min_x = H_ACT-1, min_y = V_ACT-1, max_x = 0, max_y = 0, cnt = 0; cnt width = $clog2(H_ACT*V_ACT+1).
REQ-022 If box_valid would be 0, all four committed coordinates SHALL be 0 (the downstream drawer treats zero boxes as absent).
REQ-023 If box_valid=1, any committed start/end coordinate equal to 0 SHALL be reported as 1.
REQ-024 Outputs SHALL hold their values between commits; frame_done SHALL be 0 outside COMMIT.
REQ-025 en=0 in any state SHALL force IDLE on the next clk and clear the coordinates and box_valid to 0.
REQ-026 When en=0 forces IDLE, frame_done SHALL stay 0 and no partial commit SHALL occur.
REQ-027 Single matched pixel at (x0,y0) with MIN_PIXELS<=1: start = end = (x0,y0), subject to REQ-023.

Reset
REQ-028 rstn=0 SHALL asynchronously set the FSM to IDLE, accumulators to init values, all outputs to 0, and vs_q to 0.
REQ-029 Reset asserted mid-frame SHALL discard partial statistics.
REQ-030 After reset release, the first frame edge SHALL enter SCAN without a commit; the first commit SHALL occur on the second frame edge.

Verification
REQ-031 Bench SHALL cover: window lo=hi=FF0000; 4x4 red block at x 100..103, y 50..53; MIN_PIXELS=16 -> at the next vsync edge start=(100,50), end=(103,53), box_valid=1, frame_done pulses once.
REQ-032 Bench SHALL cover: same setup with a 3x5 block (15 pixels) -> box_valid=0, all coordinates 0, frame_done=1.
REQ-033 Bench SHALL cover: matched pixels at (0,0) and (10,10) only, MIN_PIXELS=2 -> start=(1,1), end=(10,10), box_valid=1.
REQ-034 Bench SHALL cover: two separated blobs at (20,30) and (900,600) -> start=(20,30), end=(900,600).
REQ-035 Bench SHALL cover: rstn pulsed low mid-frame after 8 matches -> outputs 0 immediately; no frame_done on the next edge; the following frame reports only post-reset pixels.
REQ-036 Bench SHALL cover: en dropped for one cycle mid-frame -> coordinates and box_valid 0 on the next clk; a commit occurs only after the edge that re-enters SCAN plus one full frame.
